shared_mem_arbiter: RTL and testbench

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

---
 rtl/shared_mem_pkg.sv | 17 +
 rtl/shared_mem_arbiter_stats.sv | 19 +
 rtl/shared_mem_arbiter.sv | 118 +++++++++++
 tb/tb_shared_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_pkg.sv
// rtl/shared_mem_pkg.sv - shared types and constants for the two-core memory arbiter
package shared_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 16;

    localparam logic CORE1 = 1'b0;
    localparam logic CORE2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERV1 = 2'd1,
        SERV2 = 2'd2
    } state_t;

endpackage

// File: rtl/shared_mem_arbiter_stats.sv
// rtl/shared_mem_arbiter_stats.sv - saturating counter of cycles a request waits behind the other core
module mem_arb_stats
    import shared_mem_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - two-core single-port memory arbiter, one-cycle service per request
// Optional ARB_STATS_EN adds the conflict_cnt_o wait-cycle counter.
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [ADDR_W-1:0] addr2_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [DATA_W-1:0] wdata2_i,
    input  logic              re1_i,
    input  logic              re2_i,
    input  logic              we1_i,
    input  logic              we2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              ack1_o,
    output logic              ack2_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt_o
`endif
);

    state_t state;
    state_t nxt;
    logic   ptr;
    logic   ureq1;
    logic   ureq2;

    // A core is ignored while being served and during its ack cycle, when it drops the request.
    assign ureq1 = (re1_i | we1_i) && (state != SERV1) && !ack1_o;
    assign ureq2 = (re2_i | we2_i) && (state != SERV2) && !ack2_o;

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE: begin
                if (ureq1 && (!ureq2 || (ptr == CORE1))) nxt = SERV1;
                else if (ureq2)                          nxt = SERV2;
            end
            SERV1:   if (ureq2) nxt = SERV2;
            SERV2:   if (ureq1) nxt = SERV1;
            default: nxt = IDLE;
        endcase
    end

    // The mem_* registers double as the latched request; they are cleared whenever no service follows.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= CORE1;
            ack1_o      <= 1'b0;
            ack2_o      <= 1'b0;
            rdata1_o    <= '0;
            rdata2_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
        end else begin
            state  <= nxt;
            ack1_o <= (state == SERV1);
            ack2_o <= (state == SERV2);

            if ((state == SERV1) && mem_re_o) rdata1_o <= mem_rdata_i;
            if ((state == SERV2) && mem_re_o) rdata2_o <= mem_rdata_i;

            // The pointer rotates past whichever core wins arbitration out of IDLE.
            if ((state == IDLE) && (nxt == SERV1)) ptr <= CORE2;
            if ((state == IDLE) && (nxt == SERV2)) ptr <= CORE1;

            case (nxt)
                SERV1: begin
                    mem_addr_o  <= addr1_i;
                    mem_wdata_o <= wdata1_i;
                    mem_we_o    <= we1_i;
                    mem_re_o    <= !we1_i;
                end
                SERV2: begin
                    mem_addr_o  <= addr2_i;
                    mem_wdata_o <= wdata2_i;
                    mem_we_o    <= we2_i;
                    mem_re_o    <= !we2_i;
                end
                default: begin
                    mem_addr_o  <= '0;
                    mem_wdata_o <= '0;
                    mem_we_o    <= 1'b0;
                    mem_re_o    <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic stall;

    assign stall = ((state == SERV1) && ureq2) || ((state == SERV2) && ureq1);

    mem_arb_stats u_stats (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall),
        .cnt_o (conflict_cnt_o)
    );
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - self-checking bench for shared_mem_arbiter (ARB_STATS_EN optional)
module tb_shared_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] addr1_i, addr2_i, wdata1_i, wdata2_i;
    logic        re1_i, re2_i, we1_i, we2_i;
    logic [31:0] rdata1_o, rdata2_o;
    logic        ack1_o, ack2_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_re_o, mem_we_o;
    logic [31:0] mem_rdata_i;
`ifdef ARB_STATS_EN
    logic [15:0] conflict_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .addr1_i     (addr1_i),
        .addr2_i     (addr2_i),
        .wdata1_i    (wdata1_i),
        .wdata2_i    (wdata2_i),
        .re1_i       (re1_i),
        .re2_i       (re2_i),
        .we1_i       (we1_i),
        .we2_i       (we2_i),
        .rdata1_o    (rdata1_o),
        .rdata2_o    (rdata2_o),
        .ack1_o      (ack1_o),
        .ack2_o      (ack2_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_re_o    (mem_re_o),
        .mem_we_o    (mem_we_o),
        .mem_rdata_i (mem_rdata_i)
`ifdef ARB_STATS_EN
        ,
        .conflict_cnt_o (conflict_cnt_o)
`endif
    );

    // Memory attached to the arbiter: combinational read, write at the clock edge.
    logic [31:0] tb_mem [0:63];
    bit          mem_ready = 1'b0;

    assign mem_rdata_i = tb_mem[mem_addr_o[7:2]];

    always @(posedge clk_i) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= (i == 0) ? 32'd7 : 32'(i * 32'h11);
            mem_ready <= 1'b1;
        end else if (mem_we_o) begin
            tb_mem[mem_addr_o[7:2]] <= mem_wdata_o;
        end
    end

    // kind: 0 idle, 1 read, 2 write; late: core (1/2) that raises its request one cycle later, 0 none
    typedef struct {
        int          k1, k2, late;
        logic [31:0] a1, a2, d1, d2;
        int          e_ack1, e_ack2;
        logic [31:0] e_rd1, e_rd2;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model state: transaction-level memory image and priority pointer.
    logic [31:0] m_mem [0:63];
    int          m_ptr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Services happen one after another in arbitration order; the first is acked at start+2, the second at 3.
    task automatic model(input vec_t v, output vec_t e);
        int          kind [3];
        logic [31:0] a [3];
        logic [31:0] d [3];
        logic [31:0] rd [3];
        int          eack [3];
        int          order [2];
        int          start;
        e = v;
        kind[1] = v.k1; kind[2] = v.k2;
        a[1] = v.a1; a[2] = v.a2; d[1] = v.d1; d[2] = v.d2;
        rd[1] = 0; rd[2] = 0; eack[1] = 0; eack[2] = 0;
        order[0] = 0; order[1] = 0; start = 0;
        if (kind[1] != 0 && kind[2] != 0) begin
            order[0] = (v.late == 0) ? m_ptr : 3 - v.late;
            order[1] = 3 - order[0];
        end else if (kind[1] != 0 || kind[2] != 0) begin
            order[0] = (kind[1] != 0) ? 1 : 2;
            start    = (v.late == order[0]) ? 1 : 0;
        end
        if (order[0] != 0) eack[order[0]] = start + 2;
        if (order[1] != 0) eack[order[1]] = 3;
        for (int i = 0; i < 2; i++) begin
            if (order[i] != 0) begin
                if (kind[order[i]] == 2) m_mem[a[order[i]][7:2]] = d[order[i]];
                else                     rd[order[i]] = m_mem[a[order[i]][7:2]];
            end
        end
        if (order[0] != 0) m_ptr = 3 - order[0];
        e.e_ack1 = eack[1]; e.e_ack2 = eack[2];
        e.e_rd1  = rd[1];   e.e_rd2  = rd[2];
    endtask

    task automatic drive1(input bit on, input vec_t v);
        re1_i    = on && (v.k1 == 1);
        we1_i    = on && (v.k1 == 2);
        addr1_i  = on ? v.a1 : 32'd0;
        wdata1_i = on ? v.d1 : 32'd0;
    endtask

    task automatic drive2(input bit on, input vec_t v);
        re2_i    = on && (v.k2 == 1);
        we2_i    = on && (v.k2 == 2);
        addr2_i  = on ? v.a2 : 32'd0;
        wdata2_i = on ? v.d2 : 32'd0;
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the round.
    task automatic apply(input vec_t v, input string tag);
        int n1 = 0, n2 = 0, c1 = 0, c2 = 0, strobes = 0;
        drive1((v.k1 != 0) && (v.late != 1), v);
        drive2((v.k2 != 0) && (v.late != 2), v);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_i); #1;
            if (mem_re_o || mem_we_o) strobes++;
            if (ack1_o) begin
                n1++; c1 = k;
                if (v.k1 == 1) chk({tag, " rdata1"}, rdata1_o, v.e_rd1);
                drive1(1'b0, v);
            end
            if (ack2_o) begin
                n2++; c2 = k;
                if (v.k2 == 1) chk({tag, " rdata2"}, rdata2_o, v.e_rd2);
                drive2(1'b0, v);
            end
            if (k == 1) begin
                if (v.late == 1 && v.k1 != 0) drive1(1'b1, v);
                if (v.late == 2 && v.k2 != 0) drive2(1'b1, v);
            end
        end
        chk({tag, " ack1 count"}, 32'(n1), 32'((v.k1 != 0) ? 1 : 0));
        chk({tag, " ack2 count"}, 32'(n2), 32'((v.k2 != 0) ? 1 : 0));
        if (v.k1 != 0) chk({tag, " ack1 cycle"}, 32'(c1), 32'(v.e_ack1));
        if (v.k2 != 0) chk({tag, " ack2 cycle"}, 32'(c2), 32'(v.e_ack2));
        chk({tag, " mem strobes"}, 32'(strobes), 32'((v.k1 != 0 ? 1 : 0) + (v.k2 != 0 ? 1 : 0)));
    endtask

    task automatic model_round(input vec_t v, input string tag);
        vec_t e;
        model(v, e);
        apply(e, tag);
    endtask

    vec_t vt [6];
    vec_t vr;
    vec_t dummy;
    int   n_ack_rst;

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = (i == 0) ? 32'd7 : 32'(i * 32'h11);
        m_ptr = 1;

        vt[0] = '{k1:1, k2:1, late:0, a1:32'h0,  a2:32'h0,  d1:32'h0,  d2:32'h0,
                  e_ack1:2, e_ack2:3, e_rd1:32'h7, e_rd2:32'h7};
        vt[1] = '{k1:1, k2:2, late:0, a1:32'h0,  a2:32'h0,  d1:32'h0,  d2:32'hAB,
                  e_ack1:3, e_ack2:2, e_rd1:32'hAB, e_rd2:32'h0};
        vt[2] = '{k1:2, k2:0, late:0, a1:32'h10, a2:32'h0,  d1:32'h5,  d2:32'h0,
                  e_ack1:2, e_ack2:0, e_rd1:32'h0, e_rd2:32'h0};
        vt[3] = '{k1:1, k2:2, late:0, a1:32'h8,  a2:32'h8,  d1:32'h0,  d2:32'h9,
                  e_ack1:3, e_ack2:2, e_rd1:32'h9, e_rd2:32'h0};
        vt[4] = '{k1:2, k2:1, late:1, a1:32'h8,  a2:32'h8,  d1:32'h55, d2:32'h0,
                  e_ack1:3, e_ack2:2, e_rd1:32'h0, e_rd2:32'h9};
        vt[5] = '{k1:0, k2:1, late:2, a1:32'h0,  a2:32'h10, d1:32'h0,  d2:32'h0,
                  e_ack1:0, e_ack2:3, e_rd1:32'h0, e_rd2:32'h5};

        rst_i = 1'b1;
        drive1(1'b0, vt[0]);
        drive2(1'b0, vt[0]);
        #1;
        chk("reset ack1", 32'(ack1_o), 32'd0);
        chk("reset ack2", 32'(ack2_o), 32'd0);
        chk("reset rdata1", rdata1_o, 32'd0);
        chk("reset rdata2", rdata2_o, 32'd0);
        chk("reset mem strobes", 32'({mem_re_o, mem_we_o}), 32'd0);
        chk("reset mem_addr", mem_addr_o, 32'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            model(vt[i], dummy);
            apply(vt[i], $sformatf("vec%0d", i));
        end
        chk("write committed mem[4]", tb_mem[4], 32'h5);
        chk("late write mem[2]", tb_mem[2], 32'h55);

        // Reset while core 1's write of 3 to 0x4 is in its service cycle.
        vr = '{k1:2, k2:0, late:0, a1:32'h4, a2:32'h0, d1:32'h3, d2:32'h0,
               e_ack1:0, e_ack2:0, e_rd1:32'h0, e_rd2:32'h0};
        drive1(1'b1, vr);
        @(posedge clk_i); #1;
        chk("serv1 mem_we", 32'(mem_we_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("async rst mem_we", 32'(mem_we_o), 32'd0);
        chk("async rst mem_addr", mem_addr_o, 32'd0);
        chk("async rst mem_wdata", mem_wdata_o, 32'd0);
        chk("async rst rdata1", rdata1_o, 32'd0);
        chk("async rst rdata2", rdata2_o, 32'd0);
        drive1(1'b0, vr);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_ptr = 1;
        n_ack_rst = 0;
        for (int k = 0; k < 3; k++) begin
            if (ack1_o || ack2_o) n_ack_rst++;
            @(posedge clk_i); #1;
        end
        chk("discarded request acks", 32'(n_ack_rst), 32'd0);
        chk("aborted write mem[1]", tb_mem[1], 32'h11);

        vr = '{k1:1, k2:1, late:0, a1:32'h10, a2:32'h10, d1:32'h0, d2:32'h0,
               e_ack1:2, e_ack2:3, e_rd1:32'h5, e_rd2:32'h5};
        model(vr, dummy);
        apply(vr, "post-reset pair");

        for (int r = 0; r < 40; r++) begin
            vr.k1   = int'($urandom_range(0, 2));
            vr.k2   = int'($urandom_range(0, 2));
            vr.late = int'($urandom_range(0, 2));
            vr.a1   = 32'($urandom_range(0, 15)) << 2;
            vr.a2   = 32'($urandom_range(0, 15)) << 2;
            vr.d1   = $urandom;
            vr.d2   = $urandom;
            model_round(vr, $sformatf("rand%0d", r));
        end

`ifdef ARB_STATS_EN
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_ptr = 1;
        chk("stats reset", 32'(conflict_cnt_o), 32'd0);
        for (int p = 0; p < 3; p++) begin
            vr = '{k1:1, k2:2, late:0, a1:32'(p * 4), a2:32'(p * 4 + 32'h20), d1:32'h0, d2:32'(p),
                   e_ack1:0, e_ack2:0, e_rd1:32'h0, e_rd2:32'h0};
            model_round(vr, $sformatf("stats pair%0d", p));
        end
        chk("stats 3 conflicts", 32'(conflict_cnt_o), 32'd3);
        force dut.u_stats.cnt_o = 16'hFFFF;
        #1;
        release dut.u_stats.cnt_o;
        vr = '{k1:1, k2:1, late:0, a1:32'h0, a2:32'h4, d1:32'h0, d2:32'h0,
               e_ack1:0, e_ack2:0, e_rd1:32'h0, e_rd2:32'h0};
        model_round(vr, "stats saturate");
        chk("stats saturation", 32'(conflict_cnt_o), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
